// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send,
// 11-bit frame driven on device clock falls, ACK sample and inactivity timeout.

module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // level only moves after FILTER_LEN consecutive samples disagree with it
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       kclk_in,
  input  logic       kdata_in,
  output logic       kclk_oe,
  output logic       kdata_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_PEN  = IW'(INHIBIT_CYCLES - 2);
  // counter restarts the cycle after a fall, so firing at T-2 puts the
  // registered error pulse exactly TIMEOUT_CYCLES cycles after that fall
  localparam logic [TW-1:0] TO_FIRE  = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;

  state_t        state;
  logic [1:0]    raw, filt;
  logic          kclk_f, kdata_f, kclk_d, fall;
  logic [9:0]    frame;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic          ack_ok;

  assign raw = {kdata_in, kclk_in};

  for (genvar i = 0; i < 2; i++) begin : g_line
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
      .clk(clk), .reset(reset), .raw(raw[i]), .level(filt[i])
    );
  end

  assign kclk_f  = filt[0];
  assign kdata_f = filt[1];
  assign fall    = kclk_d & ~kclk_f;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      kclk_oe  <= 1'b0;
      kdata_oe <= 1'b0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      frame    <= '0;
      bit_cnt  <= '0;
      inh_cnt  <= '0;
      to_cnt   <= '0;
      ack_ok   <= 1'b0;
      kclk_d   <= 1'b1;
    end else begin
      kclk_d <= kclk_f;
      done   <= 1'b0;
      error  <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            frame    <= {1'b1, ~^tx_data, tx_data};  // stop, odd parity, data
            inh_cnt  <= '0;
            kclk_oe  <= 1'b1;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= INHIBIT;
          end
        end
        INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          if (inh_cnt == INH_PEN) kdata_oe <= 1'b1;
          if (inh_cnt == INH_LAST) begin
            kclk_oe <= 1'b0;
            to_cnt  <= '0;
            state   <= REQ;
          end
        end
        default: begin
          if (state == WAIT_IDLE && kclk_f && kdata_f) begin
            done     <= ack_ok;
            error    <= ~ack_ok;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (fall) begin
            to_cnt <= '0;
            case (state)
              REQ: begin
                kdata_oe <= ~frame[0];
                bit_cnt  <= 4'd1;
                state    <= SHIFT;
              end
              SHIFT: begin
                kdata_oe <= ~frame[bit_cnt];
                bit_cnt  <= bit_cnt + 1'b1;
                if (bit_cnt == 4'd9) state <= ACK;
              end
              ACK: begin
                ack_ok <= ~kdata_f;
                state  <= WAIT_IDLE;
              end
              default: ;
            endcase
          end else if (to_cnt == TO_FIRE) begin
            kclk_oe  <= 1'b0;
            kdata_oe <= 1'b0;
            error    <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000: clock-low hold before request-to-send (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000: maximum cycles between consecutive device clock falling edges (15 ms).
REQ-003 SHALL have parameter FILTER_LEN, default 4: consecutive identical samples needed to accept a new KCLK/KDATA level.
REQ-004 CLK  input  1  single system clock; all logic on its rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 tx_valid  input  1  request to send tx_data; accepted only when tx_ready=1.
REQ-007 tx_data  input  8  command byte to the keyboard (e.g. 0xED set-LEDs).
REQ-008 tx_ready  output  1  high only in IDLE.
REQ-009 kclk_in / kdata_in  input  1 each  raw PS/2 line levels, asynchronous.
REQ-010 kclk_oe / kdata_oe  output  1 each  1 = pull line low (open drain), 0 = release.
REQ-011 busy  output  1  high in every state except IDLE; the keyboard receiver ignores the bus while high.
REQ-012 done  output  1  one-cycle pulse: byte sent and ACK received.
REQ-013 error  output  1  one-cycle pulse: missing ACK or timeout.

Function
REQ-014 SHALL pass kclk_in/kdata_in through a 2-FF synchronizer, then a filter that updates the filtered level only after FILTER_LEN consecutive equal synchronized samples; the filtered level resets to 1.
REQ-015 SHALL define a falling edge as filtered KCLK going 1->0, asserted for exactly one cycle.
REQ-016 SHALL accept a transfer when tx_valid=1 and tx_ready=1 in the same cycle, latching tx_data and odd parity (parity = ~^tx_data).
REQ-017 States: IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
REQ-018 IDLE: kclk_oe=0, kdata_oe=0; on accept -> INHIBIT.
REQ-019 INHIBIT: kclk_oe=1 for exactly INHIBIT_CYCLES cycles, kdata_oe=0 for the first INHIBIT_CYCLES-1 cycles and 1 in the last; then -> REQ.
REQ-020 REQ: kclk_oe=0, kdata_oe=1 (start bit); on the first falling edge drive bit0 and go to SHIFT with bit count 1.
REQ-021 SHIFT: on each falling edge, drive the next frame bit: data bits 1..7 LSB first, then parity, then stop (kdata_oe=0); kdata_oe = ~bit; after stop is driven -> ACK.
REQ-022 ACK: on the next (11th) falling edge sample filtered KDATA; 0 = ACK good, 1 = NACK; -> WAIT_IDLE.
REQ-023 WAIT_IDLE: both lines released; when filtered KCLK=1 and KDATA=1, pulse done (ACK good) or error (NACK) and return to IDLE in the same cycle.
REQ-024 Timeout: a counter, cleared on entry to REQ and on every falling edge, increments in REQ/SHIFT/ACK/WAIT_IDLE; on reaching TIMEOUT_CYCLES SHALL release both lines, pulse error, and go to IDLE next cycle.
REQ-025 done and error SHALL never assert in the same cycle; tx_valid outside IDLE SHALL be ignored (no queueing).
REQ-026 Falling edges seen in IDLE or INHIBIT SHALL be ignored.
REQ-027 Total device clock falling edges consumed per successful transfer SHALL be 11.

Reset
REQ-028 While RESET=1 at a clock edge: state=IDLE, kclk_oe=0, kdata_oe=0, tx_ready=1, busy=0, done=0, error=0, counters=0, filtered levels=1, synchronizers=1.
REQ-029 RESET mid-transfer SHALL abort with no done/error pulse; lines are released the cycle after the reset edge.

Verification
REQ-030 Send 0xED with a device model that ACKs -> kdata_oe after falling edges 1..10 gives line bits 1,0,1,1,0,1,1,1, parity 1, stop 1; ACK low; one done pulse, no error.
REQ-031 Send 0x07 -> parity bit 0; send 0xFF -> parity 1; send 0x00 -> parity 1; each ends in done.
REQ-032 INHIBIT check (INHIBIT_CYCLES=50) -> kclk_oe high exactly 50 cycles, kdata_oe rises in cycle 50, kclk_oe falls the following cycle.
REQ-033 Device leaves KDATA high at the 11th falling edge -> error pulse once lines idle, no done.
REQ-034 TIMEOUT_CYCLES=200, device stops clocking after bit 3 -> error exactly 200 cycles after the last falling edge, both oe=0, tx_ready=1 next cycle.
REQ-035 RESET asserted in SHIFT, and 1-cycle KCLK glitches (< FILTER_LEN) during SHIFT -> immediate release/no pulses for reset; glitches produce no extra bit shifts.
